// File: rtl/string_arb_pkg.sv
// Shared types and helpers for the string request arbiter: FSM state encoding
// and a reference round-robin winner function.
package string_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int RR_MAX_REQ = 8;

  // First set bit of req searching upward from last+1, modulo n; returns last if none set.
  function automatic logic [2:0] rr_next(input logic [RR_MAX_REQ-1:0] req,
                                         input logic [2:0] last,
                                         input int n);
    logic [2:0] win;
    win = last;
    for (int k = RR_MAX_REQ; k >= 1; k--) begin
      if (k <= n && req[3'((int'(last) + k) % n)]) begin
        win = 3'((int'(last) + k) % n);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/string_req_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the first requester above
// the previous winner, wrapping around.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SRC_W-1:0] i_last,
  output logic [SRC_W-1:0] o_winner,
  output logic             o_found
);

  // Descending scan so the candidate closest to last+1 is assigned last and wins.
  always_comb begin
    o_winner = i_last;
    o_found  = |i_req;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req[SRC_W'((int'(i_last) + k) % N_REQ)]) begin
        o_winner = SRC_W'((int'(i_last) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/string_req_arbiter.sv
// Round-robin arbiter that grants a shared byte-stream datapath to one requester
// for a whole string, truncating strings longer than MAX_LEN.
module string_req_arbiter
  import string_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 64,
  localparam int SRC_W  = $clog2(N_REQ),
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        i_in_valid,
  input  logic [N_REQ*DATA_W-1:0] i_in_data,
  input  logic [N_REQ-1:0]        i_in_last,
  output logic [N_REQ-1:0]        o_in_ready,
  output logic                    o_out_valid,
  output logic [DATA_W-1:0]       o_out_data,
  output logic                    o_out_last,
  output logic [SRC_W-1:0]        o_out_src,
  input  logic                    i_out_ready,
  output logic                    o_busy,
  output logic                    o_trunc_err,
  output logic [15:0]             o_str_count
);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  logic [SRC_W-1:0]  r_grant;
  logic [SRC_W-1:0]  r_lastGrant;
  logic [SRC_W-1:0]  w_winner;
  logic              w_found;
  logic [LEN_W-1:0]  r_count;
  logic              r_truncErr;
  logic [15:0]       r_strCount;
  logic [DATA_W-1:0] w_dataArr [N_REQ];
  logic              w_gValid;
  logic              w_gLast;
  logic              w_atMax;
  logic              w_handshake;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_dataArr[gi] = i_in_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .i_req    (i_in_valid),
    .i_last   (r_lastGrant),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  assign w_gValid    = i_in_valid[r_grant];
  assign w_gLast     = i_in_last[r_grant];
  assign w_atMax     = (r_count == LEN_W'(MAX_LEN - 1));
  assign w_handshake = (r_state == XFER) && w_gValid && i_out_ready;

  assign o_out_data  = w_dataArr[r_grant];
  assign o_out_last  = w_gLast | w_atMax;
  assign o_out_src   = r_grant;
  assign o_busy      = (r_state != IDLE);
  assign o_trunc_err = r_truncErr;
  assign o_str_count = r_strCount;

  always_comb begin
    w_nextState = r_state;
    o_in_ready  = '0;
    o_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) w_nextState = XFER;
      end
      XFER: begin
        o_out_valid         = w_gValid;
        o_in_ready[r_grant] = i_out_ready;
        if (w_handshake) begin
          if (w_gLast)      w_nextState = IDLE;
          else if (w_atMax) w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        // Discard the tail of a truncated string without involving the datapath.
        o_in_ready[r_grant] = 1'b1;
        if (w_gValid && w_gLast) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= '0;
      r_lastGrant <= SRC_W'(N_REQ - 1);
      r_count     <= '0;
      r_truncErr  <= 1'b0;
      r_strCount  <= 16'd0;
    end else begin
      r_truncErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_count <= '0;
          end
        end
        XFER: begin
          if (w_handshake) begin
            r_count <= r_count + LEN_W'(1);
            if (w_gLast) begin
              r_lastGrant <= r_grant;
              r_strCount  <= r_strCount + 16'd1;
            end else if (w_atMax) begin
              r_truncErr <= 1'b1;
              r_strCount <= r_strCount + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (w_gValid && w_gLast) r_lastGrant <= r_grant;
        end
        default: ;
      endcase
    end
  end

endmodule
